// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end for one shared add/sub datapath.
// One operation in flight; result returned on a valid/ready channel.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int IDW     = 2,
  parameter int CNTW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  output logic [CNTW-1:0]          op_count,
  output logic [CNTW-1:0]          ovf_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [IDW-1:0]   id;
  } op_t;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  op_t              op_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_ovf_q;
  logic [CNTW-1:0]  op_cnt_q;
  logic [CNTW-1:0]  ovf_cnt_q;

  logic [IDW-1:0]   win_id;
  logic             win_vld;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Scan from farthest to nearest so the entry after rr_ptr wins last.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win_id  = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_vld) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign sel_a = req_a[int'(win_id)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(win_id)*WIDTH +: WIDTH];

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  assign b_eff    = op_q.b ^ {WIDTH{op_q.sub}};
  assign carry[0] = op_q.sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rc
    assign sum[i] = op_q.a[i] ^ b_eff[i] ^ carry[i];
    if (i < WIDTH-1) begin : g_c
      assign carry[i+1] = (op_q.a[i] & b_eff[i])
                        | (carry[i] & (op_q.a[i] ^ b_eff[i]));
    end
  end

  assign ovf = (op_q.a[WIDTH-1] == b_eff[WIDTH-1])
            && (sum[WIDTH-1] != op_q.a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NUM_REQ-1);
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      op_cnt_q    <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            op_q.a   <= sel_a;
            op_q.b   <= sel_b;
            op_q.sub <= req_sub[win_id];
            op_q.id  <= win_id;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= sum;
          rsp_ovf_q   <= ovf;
          rsp_id_q    <= op_q.id;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rsp_id_q;
            op_cnt_q    <= op_cnt_q + 1'b1;
            ovf_cnt_q   <= ovf_cnt_q + CNTW'(rsp_ovf_q);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign op_count  = op_cnt_q;
  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: vector table, random ops vs arithmetic model,
// round-robin, backpressure and async-reset sequences.
module tb_adder_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 2;
  localparam int CW  = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_ovf;
  logic [CW-1:0]  op_count;
  logic [CW-1:0]  ovf_count;

  adder_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .IDW(IDW), .CNTW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
    .op_count(op_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_ops  = 0;
  int exp_ovfs = 0;

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    bit          sub;
    logic [63:0] s;
    bit          o;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Exact signed arithmetic on 66 bits; overflow iff result leaves 64-bit range.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input bit sub, output logic [63:0] s,
                                output bit o);
    logic signed [65:0] sa, sb, r;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    r  = sub ? sa - sb : sa + sb;
    s  = r[63:0];
    o  = r[64] ^ r[63];
  endfunction

  task automatic set_req(input int id, input logic [63:0] a,
                         input logic [63:0] b, input bit sub);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_sub[id]      = sub;
  endtask

  task automatic run_op(input int id, input logic [63:0] a,
                        input logic [63:0] b, input bit sub,
                        input logic [63:0] es, input bit eo,
                        input string tag);
    int n;
    @(negedge clk);
    set_req(id, a, b, sub);
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_grant"}, 64'(req_ready), 64'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    chk({tag, "_exec_nvalid"}, 64'(rsp_valid), 64'(0));
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_sum"}, rsp_sum, es);
    chk({tag, "_ovf"}, 64'(rsp_ovf), 64'(eo));
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    exp_ops++;
    exp_ovfs += int'(eo);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_opcnt"}, 64'(op_count), 64'(exp_ops));
    chk({tag, "_ovfcnt"}, 64'(ovf_count), 64'(exp_ovfs));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ops  = 0;
    exp_ovfs = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 64'h7FFF_FFFF_FFFF_FFFF;
      1: pick = 64'h8000_0000_0000_0000;
      2: pick = 64'h0;
      3: pick = '1;
      default: pick = {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] es, a, b;
    bit          eo, sub;
    int          id, g, ng, nr, cyc;
    int          order[5];
    int          gq[$];
    logic [63:0] hold_sum;

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_sum", rsp_sum, 64'(0));
    chk("rst_id", 64'(rsp_id), 64'(0));
    chk("rst_ovf", 64'(rsp_ovf), 64'(0));
    chk("rst_opcnt", 64'(op_count), 64'(0));
    chk("rst_ovfcnt", 64'(ovf_count), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0};
    tbl[1] = '{2, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[2] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b1};
    tbl[3] = '{3, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[4] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b0};
    tbl[5] = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               1'b0, 64'd0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub,
             tbl[i].s, tbl[i].o, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      id  = $urandom_range(0, N-1);
      a   = pick();
      b   = pick();
      sub = 1'($urandom_range(0, 1));
      model(a, b, sub, es, eo);
      run_op(id, a, b, sub, es, eo, $sformatf("rnd%0d", i));
    end

    // Round-robin with everyone continuously valid
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      set_req(i, 64'(i*100 + 1), 64'(i + 1), 1'b0);
    end
    req_valid = '1;
    ng = 0;
    nr = 0;
    cyc = 0;
    while (nr < 5 && cyc < 60) begin
      #1;
      chk("rr_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      if (req_ready != 0 && ng < 5) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk("rr_grant", 64'(g), 64'(order[ng]));
        gq.push_back(g);
        ng++;
      end
      if (rsp_valid && gq.size() > 0) begin
        g = gq.pop_front();
        chk("rr_rsp_id", 64'(rsp_id), 64'(g));
        chk("rr_sum", rsp_sum, 64'(g*100 + 1 + g + 1));
        nr++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    chk("rr_timeout", 64'(cyc < 60), 64'(1));
    exp_ops = 5;
    #1;
    chk("rr_opcnt", 64'(op_count), 64'(exp_ops));

    // Backpressure: rr_ptr=0 so req1 beats a waiting req0
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 64'd1000, 64'd1, 1'b1);
    set_req(0, 64'd3, 64'd4, 1'b0);
    req_valid = 4'b0011;
    #1;
    chk("bp_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    chk("bp_exec_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("bp_valid", 64'(rsp_valid), 64'(1));
    hold_sum = rsp_sum;
    chk("bp_sum", hold_sum, 64'd999);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
      chk("bp_hold_sum", rsp_sum, 64'd999);
      chk("bp_hold_id", 64'(rsp_id), 64'(1));
      chk("bp_hold_ready", 64'(req_ready), 64'(0));
      chk("bp_hold_cnt", 64'(op_count), 64'(exp_ops));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    exp_ops++;
    chk("bp_done", 64'(rsp_valid), 64'(0));
    chk("bp_opcnt", 64'(op_count), 64'(exp_ops));
    chk("bp_req0_ready", 64'(req_ready), 64'(4'b0001));
    req_valid[0] = 1'b0;
    #1;
    chk("bp_withdraw", 64'(req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("bp_no_op", 64'(state_idle_check()), 64'(1));

    // Async reset while req1 sits in EXEC
    @(negedge clk);
    set_req(1, 64'd50, 64'd60, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("ar_grant", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(rsp_valid), 64'(0));
    chk("ar_sum", rsp_sum, 64'(0));
    chk("ar_id", 64'(rsp_id), 64'(0));
    chk("ar_opcnt", 64'(op_count), 64'(0));
    chk("ar_ovfcnt", 64'(ovf_count), 64'(0));
    exp_ops  = 0;
    exp_ovfs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_dropped", 64'(rsp_valid), 64'(0));
    set_req(0, 64'd8, 64'd9, 1'b0);
    req_valid = 4'b0011;
    #1;
    chk("ar_prio0", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("ar_rsp_id", 64'(rsp_id), 64'(0));
    chk("ar_rsp_sum", rsp_sum, 64'd17);
    exp_ops++;
    run_op(1, 64'd50, 64'd60, 1'b0, 64'd110, 1'b0, "ar_req1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic bit state_idle_check();
    return (rsp_valid == 1'b0) && (op_count == CW'(exp_ops));
  endfunction

endmodule
